logic_op_arbiter: RTL and testbench

Shares a single bitwise logic-op unit between two requesters with round-robin arbitration and a valid/ready handshake on every side. Each request carries two operands and an opcode. The granted request is computed in one `logic_op_unit` instance and held in a one-entry output register until the consumer takes it. The block sits in front of the AND/OR datapath cells, so one physical unit serves both upstream paths.

---
 rtl/logic_op_arbiter_pkg.sv | 19 +
 rtl/logic_op_unit.sv | 29 ++
 rtl/logic_op_arbiter.sv | 107 ++++++++++
 tb/tb_logic_op_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/logic_op_arbiter_pkg.sv
// Shared opcode constants and state encodings for the logic-op arbiter slice.
// Imported by the shared logic_op_unit and the logic_op_arbiter top level.
package logic_op_arbiter_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } occ_e;

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise logic-op unit shared between the two requesters.
// XOR support is built only when LOGIC_ARB_XOR_EN is defined; otherwise opcode 10 is an error.
module logic_op_unit
  import logic_op_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [OP_W-1:0] op,
  input  logic [W-1:0]    a,
  input  logic [W-1:0]    b,
  output logic [W-1:0]    y,
  output logic            err
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op_e'(op))
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
`ifdef LOGIC_ARB_XOR_EN
      OP_XOR: y = a ^ b;
`endif
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic_op_unit between two requesters, with a one-entry
// response register. Optional XOR opcode is enabled by defining LOGIC_ARB_XOR_EN.
module logic_op_arbiter
  import logic_op_arbiter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OP_W-1:0] req0_op,
  input  logic [W-1:0]    req0_a,
  input  logic [W-1:0]    req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OP_W-1:0] req1_op,
  input  logic [W-1:0]    req1_a,
  input  logic [W-1:0]    req1_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_data,
  output logic            rsp_id,
  output logic            rsp_err
);

  occ_e            state_q, state_d;
  logic            last_q, last_d;
  logic [W-1:0]    data_q, data_d;
  logic            id_q, id_d;
  logic            err_q, err_d;

  logic            can_accept;
  logic            gnt0, gnt1;
  logic            accept;
  logic            grant_id;
  logic [OP_W-1:0] op_sel;
  logic [W-1:0]    a_sel, b_sel;
  logic [W-1:0]    unit_y;
  logic            unit_err;

  // Grants are one-hot and only ever go to a valid requester; on contention the
  // requester that did not win last time gets the slot.
  assign gnt0       = req0_valid & (~req1_valid | last_q);
  assign gnt1       = req1_valid & (~req0_valid | ~last_q);
  assign can_accept = (state_q == ST_EMPTY) | rsp_ready;
  assign accept     = can_accept & (gnt0 | gnt1);
  assign grant_id   = gnt1;

  assign req0_ready = can_accept & gnt0;
  assign req1_ready = can_accept & gnt1;

  assign op_sel = grant_id ? req1_op : req0_op;
  assign a_sel  = grant_id ? req1_a  : req0_a;
  assign b_sel  = grant_id ? req1_b  : req0_b;

  logic_op_unit #(.W(W)) u_op_unit (
    .op  (op_sel),
    .a   (a_sel),
    .b   (b_sel),
    .y   (unit_y),
    .err (unit_err)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    data_d  = data_q;
    id_d    = id_q;
    err_d   = err_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (rsp_ready && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (accept) begin
      last_d = grant_id;
      data_d = unit_y;
      id_d   = grant_id;
      err_d  = unit_err;
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  // The response payload is reset too, so outputs read 0 straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      last_q  <= 1'b1;
      data_q  <= '0;
      id_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed, table-driven bench for logic_op_arbiter (W=8); expectations follow LOGIC_ARB_XOR_EN.
module tb_logic_op_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [1:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_id, rsp_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  logic_op_arbiter #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_err    (rsp_err)
  );

  typedef struct packed {
    logic       v0;
    logic [1:0] op0;
    logic [7:0] a0;
    logic [7:0] b0;
    logic       v1;
    logic [1:0] op1;
    logic [7:0] a1;
    logic [7:0] b1;
    logic       rdy0;
    logic       rdy1;
    logic [7:0] data;
    logic       id;
    logic       err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [1:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                       input logic v1, input logic [1:0] op1, input logic [7:0] a1, input logic [7:0] b1);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [7:0] d, input logic id, input logic e);
    check({tag, " rsp_valid"}, 64'(rsp_valid), 64'(v));
    check({tag, " rsp_data"},  64'(rsp_data),  64'(d));
    check({tag, " rsp_id"},    64'(rsp_id),    64'(id));
    check({tag, " rsp_err"},   64'(rsp_err),   64'(e));
  endtask

  initial begin
    // {v0,op0,a0,b0, v1,op1,a1,b1, rdy0,rdy1, data,id,err}; rsp_ready held high
    vecs[0] = {1'b1, 2'b00, 8'hF0, 8'h3C, 1'b1, 2'b01, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[1] = {1'b1, 2'b00, 8'hF0, 8'h3C, 1'b1, 2'b01, 8'hF0, 8'h3C, 1'b0, 1'b1, 8'hFC, 1'b1, 1'b0};
    vecs[2] = {1'b1, 2'b00, 8'hF0, 8'h3C, 1'b1, 2'b01, 8'hF0, 8'h3C, 1'b1, 1'b0, 8'h30, 1'b0, 1'b0};
    vecs[3] = {1'b1, 2'b00, 8'hF0, 8'h3C, 1'b1, 2'b01, 8'hF0, 8'h3C, 1'b0, 1'b1, 8'hFC, 1'b1, 1'b0};
    vecs[4] = {1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 8'hAA, 8'h0F, 1'b0, 1'b1, 8'h0A, 1'b1, 1'b0};
`ifdef LOGIC_ARB_XOR_EN
    vecs[5] = {1'b1, 2'b10, 8'hAA, 8'h0F, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
`else
    vecs[5] = {1'b1, 2'b10, 8'hAA, 8'h0F, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
`endif
    vecs[6] = {1'b1, 2'b11, 8'hAA, 8'h0F, 1'b0, 2'b00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[7] = {1'b1, 2'b00, 8'hFF, 8'hFF, 1'b1, 2'b01, 8'h55, 8'h0F, 1'b0, 1'b1, 8'h5F, 1'b1, 1'b0};
    vecs[8] = {1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0, 2'b01, 8'h55, 8'h0F, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};

    rst = 1'b1;
    rsp_ready = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_rsp("reset", 1'b0, 8'h00, 1'b0, 1'b0);
    check("reset req0_ready idle", 64'(req0_ready), 64'd0);
    check("reset req1_ready idle", 64'(req1_ready), 64'd0);
    req0_valid = 1'b1;
    #1;
    check("reset req0_ready follows valid", 64'(req0_ready), 64'd1);
    req1_valid = 1'b1;
    #1;
    check("first contention req0_ready", 64'(req0_ready), 64'd1);
    check("first contention req1_ready", 64'(req1_ready), 64'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i].v0, vecs[i].op0, vecs[i].a0, vecs[i].b0,
            vecs[i].v1, vecs[i].op1, vecs[i].a1, vecs[i].b1);
      #1;
      check($sformatf("vec%0d req0_ready", i), 64'(req0_ready), 64'(vecs[i].rdy0));
      check($sformatf("vec%0d req1_ready", i), 64'(req1_ready), 64'(vecs[i].rdy1));
      @(posedge clk);
      #1;
      check_rsp($sformatf("vec%0d", i), 1'b1, vecs[i].data, vecs[i].id, vecs[i].err);
    end
    @(negedge clk);
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    check("idle drain rsp_valid", 64'(rsp_valid), 64'd0);

    // Backpressure, then drain plus accept on the same edge (last = 0 here)
    @(negedge clk);
    drive(1'b1, 2'b00, 8'hFF, 8'h81, 1'b0, 2'b00, 8'h00, 8'h00);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 2'b00, 8'h0F, 8'h3C, 1'b1, 2'b01, 8'h10, 8'h01);
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_rsp($sformatf("bp%0d", c), 1'b1, 8'h81, 1'b0, 1'b0);
      check($sformatf("bp%0d req0_ready", c), 64'(req0_ready), 64'd0);
      check($sformatf("bp%0d req1_ready", c), 64'(req1_ready), 64'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp release req0_ready", 64'(req0_ready), 64'd0);
    check("bp release req1_ready", 64'(req1_ready), 64'd1);
    @(posedge clk);
    #1;
    check_rsp("drain+accept", 1'b1, 8'h11, 1'b1, 1'b0);
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    check("after swap req0_ready", 64'(req0_ready), 64'd1);
    @(posedge clk);
    #1;
    check_rsp("no bubble", 1'b1, 8'h0C, 1'b0, 1'b0);
    @(negedge clk);
    req0_valid = 1'b0;
    @(posedge clk);
    #1;
    check("bp final drain rsp_valid", 64'(rsp_valid), 64'd0);

    // Reset while a response is held
    @(negedge clk);
    rsp_ready = 1'b0;
    drive(1'b1, 2'b01, 8'h01, 8'h02, 1'b0, 2'b00, 8'h00, 8'h00);
    @(posedge clk);
    #1;
    check_rsp("pre-reset held", 1'b1, 8'h03, 1'b0, 1'b0);
    @(negedge clk);
    req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    check_rsp("async reset", 1'b0, 8'h00, 1'b0, 1'b0);
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_rsp("held in reset", 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-reset req0_ready", 64'(req0_ready), 64'd1);
    check("post-reset req1_ready", 64'(req1_ready), 64'd0);
    @(posedge clk);
    #1;
    check_rsp("post-reset grant", 1'b1, 8'h03, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
